calc_port_responder: RTL and testbench

//  Synthesizable responder for one calc1-style request port: the DUV-side end of the cmd/data -> resp/data protocol our benches drive.

---
 rtl/calc_port_responder_pkg.sv | 23 ++
 rtl/calc_port_responder_alu.sv | 60 ++++++
 rtl/calc_port_responder.sv | 119 +++++++++++
 tb/tb_calc_port_responder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_port_responder_pkg.sv
// Shared encodings for the calc1-style request port: commands, responses and
// the responder FSM states.
package calc_pkg;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPND2,
        ST_WAIT,
        ST_EXEC,
        ST_RESP
    } calc_state_e;

endpackage

// File: rtl/calc_port_responder_alu.sv
// Combinational calculator core: (cmd, op1, op2) -> (resp, data), unsigned.
// Vectors use [0:N] ordering, so bit 0 is the MSB.
module calc_alu
    import calc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [0:3]        cmd_i,
    input  logic [0:DATA_W-1] op1_i,
    input  logic [0:DATA_W-1] op2_i,
    output logic [0:1]        resp_o,
    output logic [0:DATA_W-1] data_o
);

    logic [3:0]         cmd;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [DATA_W:0]    sum;
    logic [SHAMT_W-1:0] shamt;

    assign cmd   = cmd_i;
    assign a     = op1_i;
    assign b     = op2_i;
    assign sum   = {1'b0, a} + {1'b0, b};
    // The shift amount is the numerically low bits, which sit at the right end.
    assign shamt = op2_i[DATA_W-SHAMT_W:DATA_W-1];

    always_comb begin
        resp_o = RESP_ERR;
        data_o = '0;
        case (cmd)
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    resp_o = RESP_OK;
                    data_o = sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (a >= b) begin
                    resp_o = RESP_OK;
                    data_o = a - b;
                end
            end
            CMD_SHL: begin
                resp_o = RESP_OK;
                data_o = a << shamt;
            end
            CMD_SHR: begin
                resp_o = RESP_OK;
                data_o = a >> shamt;
            end
            default: begin
                resp_o = RESP_ERR;
                data_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/calc_port_responder.sv
// DUV-side responder for one calc1 request port: captures cmd+op1, then op2,
// optionally waits EXTRA_LAT cycles, and presents a one-cycle registered response.
module calc_port_responder
    import calc_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int SHAMT_W   = 5,
    parameter int EXTRA_LAT = 0
) (
    input  logic              c_clk,
    input  logic              reset_n,
    input  logic [0:3]        req_cmd_in,
    input  logic [0:DATA_W-1] req_data_in,
    output logic [0:1]        out_resp,
    output logic [0:DATA_W-1] out_data,
    output logic              busy
);

    localparam logic [3:0] WAIT_INIT = (EXTRA_LAT > 0) ? 4'(EXTRA_LAT - 1) : 4'd0;

    calc_state_e       state_q;
    logic [0:3]        cmd_q;
    logic [0:DATA_W-1] op1_q;
    logic [0:DATA_W-1] op2_q;
    logic [3:0]        wait_cnt_q;
    logic              res_vld_q;
    logic [0:1]        res_resp_q;
    logic [0:DATA_W-1] res_data_q;
    logic [0:1]        out_resp_q;
    logic [0:DATA_W-1] out_data_q;

    logic [0:1]        alu_resp_d;
    logic [0:DATA_W-1] alu_data_d;

    calc_alu #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_alu (
        .cmd_i  (cmd_q),
        .op1_i  (op1_q),
        .op2_i  (op2_q),
        .resp_o (alu_resp_d),
        .data_o (alu_data_d)
    );

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            wait_cnt_q <= '0;
            res_vld_q  <= 1'b0;
            res_resp_q <= RESP_NONE;
            res_data_q <= '0;
            out_resp_q <= RESP_NONE;
            out_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_cmd_in != CMD_NOP) begin
                        cmd_q   <= req_cmd_in;
                        op1_q   <= req_data_in;
                        state_q <= ST_OPND2;
                    end
                end
                ST_OPND2: begin
                    op2_q <= req_data_in;
                    if (EXTRA_LAT > 0) begin
                        wait_cnt_q <= WAIT_INIT;
                        state_q    <= ST_WAIT;
                    end else begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= ST_EXEC;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_EXEC: begin
                    // ALU result is staged one cycle before it reaches the port,
                    // which places the response three edges after the command.
                    if (!res_vld_q) begin
                        res_resp_q <= alu_resp_d;
                        res_data_q <= alu_data_d;
                        res_vld_q  <= 1'b1;
                    end else begin
                        out_resp_q <= res_resp_q;
                        out_data_q <= res_data_q;
                        res_vld_q  <= 1'b0;
                        state_q    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    out_resp_q <= RESP_NONE;
                    out_data_q <= '0;
                    if (req_cmd_in != CMD_NOP) begin
                        cmd_q   <= req_cmd_in;
                        op1_q   <= req_data_in;
                        state_q <= ST_OPND2;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_resp = out_resp_q;
    assign out_data = out_data_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_calc_port_responder.sv
// Bench for calc_port_responder: two instances (EXTRA_LAT 0 and 3) share one
// cycle-indexed stimulus stream; expected responses come from a spec-level model.
module tb_calc_port_responder;

    localparam int NCYC    = 720;
    localparam int RST_CYC = 620;
    localparam int REC_CYC = 630;
    localparam int LAT0    = 0;
    localparam int LAT1    = 3;

    logic        c_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [0:3]  req_cmd_in = '0;
    logic [0:31] req_data_in = '0;
    logic [0:1]  resp0, resp1;
    logic [0:31] data0, data1;
    logic        busy0, busy1;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [3:0]  cmd_arr  [NCYC];
    logic [31:0] data_arr [NCYC];
    bit          busy_exp0 [NCYC];
    bit          busy_exp1 [NCYC];

    // {due_edge[15:0], resp[1:0], data[31:0]}
    logic [49:0] exp_q0[$];
    logic [49:0] exp_q1[$];

    calc_port_responder #(.DATA_W(32), .SHAMT_W(5), .EXTRA_LAT(LAT0)) dut0 (
        .c_clk       (c_clk),
        .reset_n     (reset_n),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (resp0),
        .out_data    (data0),
        .busy        (busy0)
    );

    calc_port_responder #(.DATA_W(32), .SHAMT_W(5), .EXTRA_LAT(LAT1)) dut1 (
        .c_clk       (c_clk),
        .reset_n     (reset_n),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (resp1),
        .out_data    (data1),
        .busy        (busy1)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    task automatic ref_calc(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                            output logic [1:0] r, output logic [31:0] d);
        longint sa;
        longint sb;
        sa = longint'(a);
        sb = longint'(b);
        r = 2'd2;
        d = 32'h0;
        case (cmd)
            4'd1: if (sa + sb <= 64'h0000_0000_FFFF_FFFF) begin r = 2'd1; d = 32'(sa + sb); end
            4'd2: if (sb <= sa) begin r = 2'd1; d = 32'(sa - sb); end
            4'd5: begin r = 2'd1; d = a << (b % 32); end
            4'd6: begin r = 2'd1; d = a >> (b % 32); end
            default: begin r = 2'd2; d = 32'h0; end
        endcase
    endtask

    // A port accepts a nonzero cmd whenever it is free; it answers after edge
    // i+3+lat and is free again from edge i+4+lat. Operand 2 is the next cycle's data.
    task automatic run_model(input int k, input int lat, input int lo, input int hi);
        int free_at;
        logic [1:0] r;
        logic [31:0] d;
        free_at = lo;
        for (int i = lo; i < hi; i++) begin
            if (i >= free_at && cmd_arr[i] != 4'd0) begin
                ref_calc(cmd_arr[i], data_arr[i], data_arr[i+1], r, d);
                if (k == 0) exp_q0.push_back({16'(i + 3 + lat), r, d});
                else        exp_q1.push_back({16'(i + 3 + lat), r, d});
                for (int e = i; e <= i + 3 + lat; e++) begin
                    if (k == 0) busy_exp0[e] = 1'b1;
                    else        busy_exp1[e] = 1'b1;
                end
                free_at = i + 4 + lat;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 40));
            2:       return 32'hFFFF_FFC0 | 32'($urandom_range(0, 63));
            default: return 32'h8000_0000 >> $urandom_range(0, 31);
        endcase
    endfunction

    function automatic logic [3:0] rand_cmd();
        int v;
        if ($urandom_range(0, 2) == 0) return 4'd0;
        v = $urandom_range(0, 9);
        if (v <= 2) return 4'd1;
        if (v <= 4) return 4'd2;
        if (v == 5) return 4'd5;
        if (v == 6) return 4'd6;
        return 4'($urandom_range(1, 15));
    endfunction

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic check_port(input int k, input logic [1:0] r, input logic [31:0] d, input logic b);
        logic [49:0] e;
        int edge_i;
        int qn;
        bit exp_b;
        edge_i = cyc - 1;
        exp_b  = (k == 0) ? busy_exp0[edge_i] : busy_exp1[edge_i];
        qn     = (k == 0) ? exp_q0.size() : exp_q1.size();
        n_checks++;
        if (b !== exp_b) begin
            n_fail++;
            $display("FAIL busy port%0d edge %0d: got %0b expected %0b", k, edge_i, b, exp_b);
        end
        if (r !== 2'd0) begin
            n_checks++;
            if (qn == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp port%0d edge %0d: got resp %0d data %h expected no response",
                         k, edge_i, r, d);
            end else begin
                if (k == 0) e = exp_q0.pop_front();
                else        e = exp_q1.pop_front();
                if (r !== e[33:32] || d !== e[31:0] || edge_i != int'(e[49:34])) begin
                    n_fail++;
                    $display("FAIL resp port%0d: got resp %0d data %h at edge %0d expected resp %0d data %h at edge %0d",
                             k, r, d, edge_i, e[33:32], e[31:0], int'(e[49:34]));
                end
            end
        end else begin
            n_checks++;
            if (d !== 32'h0) begin
                n_fail++;
                $display("FAIL idle_data port%0d edge %0d: got %h expected 00000000", k, edge_i, d);
            end
            if (qn > 0) begin
                e = (k == 0) ? exp_q0[0] : exp_q1[0];
                if (int'(e[49:34]) < edge_i) begin
                    if (k == 0) void'(exp_q0.pop_front());
                    else        void'(exp_q1.pop_front());
                    n_checks++;
                    n_fail++;
                    $display("FAIL missing_resp port%0d: got none expected resp %0d data %h at edge %0d",
                             k, e[33:32], e[31:0], int'(e[49:34]));
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge c_clk);
            if (cyc >= 1 && cyc < NCYC - 1) begin
                check_port(0, resp0, data0, busy0);
                check_port(1, resp1, data1, busy1);
            end
        end
    end

    // ---------------- driver ----------------
    initial begin
        forever begin
            @(negedge c_clk);
            if (cyc < NCYC) begin
                req_cmd_in  = cmd_arr[cyc];
                req_data_in = data_arr[cyc];
            end
        end
    end

    // ---------------- main sequence ----------------
    logic [3:0]  dc [12] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd1, 4'd2};
    logic [31:0] d1 [12] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h1FFF_FFFF, 32'h0000_0001,
                             32'h0000_000F, 32'h0000_0005, 32'h0000_0001, 32'h8000_0000,
                             32'hDEAD_BEEF, 32'h1234_5678, 32'h7FFF_FFFF, 32'h0000_0000};
    logic [31:0] d2 [12] = '{32'h01FF_FFFF, 32'h0000_0001, 32'h1FFF_FFFF, 32'h0000_000F,
                             32'h0000_0001, 32'h0000_0005, 32'h0000_0024, 32'h0000_001F,
                             32'h0000_0005, 32'h0000_0009, 32'h8000_0000, 32'h0000_0000};

    initial begin
        int c;
        for (int i = 0; i < NCYC; i++) begin
            cmd_arr[i]   = 4'd0;
            data_arr[i]  = 32'h0;
            busy_exp0[i] = 1'b0;
            busy_exp1[i] = 1'b0;
        end
        // Directed operations, ten cycles apart so both ports are idle at each.
        for (int j = 0; j < 12; j++) begin
            c = 4 + 10 * j;
            cmd_arr[c]    = dc[j];
            data_arr[c]   = d1[j];
            data_arr[c+1] = d2[j];
            cmd_arr[c+1]  = 4'($urandom_range(1, 15));
            if (j == 9) begin
                cmd_arr[c+2]  = 4'd7;
                data_arr[c+2] = 32'hCAFE_0001;
            end
        end
        for (int i = 125; i < RST_CYC - 20; i++) begin
            cmd_arr[i]  = rand_cmd();
            data_arr[i] = rand_data();
        end
        cmd_arr[RST_CYC]    = 4'd1;
        data_arr[RST_CYC]   = 32'h0000_0005;
        data_arr[RST_CYC+1] = 32'h0000_0006;
        cmd_arr[REC_CYC]    = 4'd1;
        data_arr[REC_CYC]   = 32'h0000_0001;
        data_arr[REC_CYC+1] = 32'h01FF_FFFF;
        for (int i = REC_CYC + 4; i < NCYC - 12; i++) begin
            cmd_arr[i]  = rand_cmd();
            data_arr[i] = rand_data();
        end

        run_model(0, LAT0, 4, RST_CYC);
        run_model(1, LAT1, 4, RST_CYC);
        busy_exp0[RST_CYC] = 1'b1;
        busy_exp1[RST_CYC] = 1'b1;
        run_model(0, LAT0, REC_CYC, NCYC - 12);
        run_model(1, LAT1, REC_CYC, NCYC - 12);

        #3;
        check_eq("reset_resp0", 64'(resp0), 64'd0);
        check_eq("reset_data0", 64'(data0), 64'd0);
        check_eq("reset_busy0", 64'(busy0), 64'd0);
        check_eq("reset_resp1", 64'(resp1), 64'd0);
        check_eq("reset_data1", 64'(data1), 64'd0);
        check_eq("reset_busy1", 64'(busy1), 64'd0);

        wait (cyc == 2);
        @(negedge c_clk);
        reset_n = 1'b1;

        // Reset lands just after edge E1 of the add issued at RST_CYC.
        wait (cyc == RST_CYC + 2);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_resp0", 64'(resp0), 64'd0);
        check_eq("midrst_data0", 64'(data0), 64'd0);
        check_eq("midrst_busy0", 64'(busy0), 64'd0);
        check_eq("midrst_resp1", 64'(resp1), 64'd0);
        check_eq("midrst_data1", 64'(data1), 64'd0);
        check_eq("midrst_busy1", 64'(busy1), 64'd0);
        @(negedge c_clk);
        @(negedge c_clk);
        reset_n = 1'b1;

        wait (cyc == NCYC - 1);
        @(negedge c_clk);
        check_eq("leftover_q0", 64'(exp_q0.size()), 64'd0);
        check_eq("leftover_q1", 64'(exp_q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
